// File: rtl/pipe_pkg.sv
// Shared types and constants for the 8-bit pipeline fetch front end.
package pipe_pkg;

  typedef logic [7:0] word_t;

  // Fetch stage control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  // One buffered fetch: the instruction word and the address following it.
  typedef struct packed {
    word_t inst;
    word_t pc_calc;
  } fetch_entry_t;

  localparam word_t RESET_PC = 8'h00;

endpackage

// File: rtl/prefetch_fifo.sv
// Small synchronous FIFO holding fetched instructions ahead of decode.
// Flush empties it and wins over push/pop. When empty, the head output keeps
// the last value presented so decode sees a stable word.
module prefetch_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     flush,
  input  logic                     push,
  input  pipe_pkg::fetch_entry_t   push_data,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output pipe_pkg::fetch_entry_t   head_data
);
  import pipe_pkg::*;

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t   mem [DEPTH];
  fetch_entry_t   last;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = empty ? last : mem[rd_ptr];

  // Entry storage: written on an accepted push, never reset.
  always_ff @(posedge clock) begin
    if (resetn && !flush && do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, occupancy and the held-output register.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last   <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      if (!empty) begin
        last <= mem[rd_ptr];
      end
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        last   <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_prefetch_stage.sv
// Instruction-fetch front end: owns the PC, issues requests to a
// one-cycle-latency instruction memory, buffers responses in a prefetch FIFO
// and handles taken-jump redirects by flushing and bumping the fetch epoch.
module fetch_prefetch_stage #(
  parameter int              DEPTH    = 4,
  parameter pipe_pkg::word_t RESET_PC = pipe_pkg::RESET_PC
) (
  input  logic       clock,
  input  logic       resetn,
  output logic       imem_req,
  output logic [7:0] imem_addr,
  input  logic       imem_rvalid,
  input  logic [7:0] imem_rdata,
  input  logic       stall,
  input  logic       redirect,
  input  logic [7:0] redirect_pc,
  output logic [7:0] inst,
  output logic [7:0] pc_calc,
  output logic       if_valid
);
  import pipe_pkg::*;

  localparam int            CW        = $clog2(DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_OCC = (CW+1)'(DEPTH);

  fetch_state_t   state;
  word_t          fetch_pc;
  logic           epoch;
  logic           inflight;
  logic           tag_epoch;
  word_t          tag_addr;

  logic [CW-1:0]  fifo_count;
  logic           fifo_full;
  logic           fifo_empty;
  fetch_entry_t   head;
  fetch_entry_t   push_entry;
  logic [CW:0]    occupancy;
  logic           issue;
  logic           accept;
  logic           pop;

  // Buffered plus outstanding words must always fit in the FIFO.
  assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
  assign issue     = (state == FETCH) && !redirect && !fifo_full &&
                     (occupancy < DEPTH_OCC);
  assign imem_req  = issue;
  assign imem_addr = fetch_pc;

  // A response counts only if it belongs to the live request of this epoch.
  assign accept     = imem_rvalid && inflight && (tag_epoch == epoch) && !redirect;
  assign push_entry = '{inst: imem_rdata, pc_calc: tag_addr + 8'd1};
  assign pop        = !fifo_empty && !stall;

  assign if_valid = !fifo_empty;
  assign inst     = head.inst;
  assign pc_calc  = head.pc_calc;

  // Control FSM, PC, epoch and request tag.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      epoch     <= 1'b0;
      inflight  <= 1'b0;
      tag_epoch <= 1'b0;
      tag_addr  <= 8'h00;
    end else if (redirect) begin
      state    <= FLUSH;
      fetch_pc <= redirect_pc;
      epoch    <= ~epoch;
      inflight <= 1'b0;
    end else begin
      case (state)
        IDLE:    state <= FETCH;
        FETCH:   state <= FETCH;
        FLUSH:   state <= FETCH;
        default: state <= IDLE;
      endcase
      // Memory answers exactly one cycle later, so inflight mirrors issue.
      inflight <= issue;
      if (issue) begin
        fetch_pc  <= fetch_pc + 8'd1;
        tag_epoch <= epoch;
        tag_addr  <= fetch_pc;
      end
    end
  end

  prefetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock     (clock),
    .resetn    (resetn),
    .flush     (redirect),
    .push      (accept),
    .push_data (push_entry),
    .pop       (pop),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head_data (head)
  );

endmodule

// File: tb/tb_fetch_prefetch_stage.sv
// Directed bench for fetch_prefetch_stage with a one-cycle memory returning
// data equal to its address.
module tb_fetch_prefetch_stage;

  logic       clock = 1'b0;
  logic       resetn;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_rvalid = 1'b0;
  logic [7:0] imem_rdata  = 8'h00;
  logic       stall;
  logic       redirect;
  logic [7:0] redirect_pc;
  logic [7:0] inst;
  logic [7:0] pc_calc;
  logic       if_valid;
  logic       force_rvalid = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  fetch_prefetch_stage #(
    .DEPTH    (4),
    .RESET_PC (8'h00)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst        (inst),
    .pc_calc     (pc_calc),
    .if_valid    (if_valid)
  );

  always #5 clock = ~clock;

  // Instruction memory: one-cycle latency, data = address.
  always @(posedge clock) begin
    imem_rvalid <= imem_req || force_rvalid;
    imem_rdata  <= imem_addr;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int s = 0; s < n; s++) begin
      @(posedge clock);
      @(negedge clock);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [7:0] i, input logic [7:0] p);
    check({tag, ".if_valid"}, {7'd0, if_valid}, {7'd0, v});
    check({tag, ".inst"}, inst, i);
    check({tag, ".pc_calc"}, pc_calc, p);
  endtask

  initial begin
    resetn      = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 8'h00;
    @(negedge clock);
    step(1);
    check_out("reset", 1'b0, 8'h00, 8'h00);
    check("reset.req", {7'd0, imem_req}, 8'h00);

    // Free run from reset: first valid three cycles after release.
    resetn = 1'b1;
    #1;
    check("idle.req", {7'd0, imem_req}, 8'h00);
    step(1);
    check("c1.req", {7'd0, imem_req}, 8'h01);
    check("c1.addr", imem_addr, 8'h00);
    step(1);
    check("c2.valid", {7'd0, if_valid}, 8'h00);
    check("c2.addr", imem_addr, 8'h01);
    step(1);
    for (int i = 0; i < 4; i++) begin
      check_out("run", 1'b1, 8'(i), 8'(i + 1));
      step(1);
    end

    // Stall six cycles: FIFO fills, requests stop, head holds 04.
    stall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      check_out("stall", 1'b1, 8'h04, 8'h05);
      if (i >= 2) check("stall.req", {7'd0, imem_req}, 8'h00);
      step(1);
    end
    stall = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check_out("drain", 1'b1, 8'(4 + i), 8'(5 + i));
      step(1);
    end

    // Build 3 buffered + 1 in flight, then redirect to 40.
    check_out("pre_redir", 1'b1, 8'h0A, 8'h0B);
    stall = 1'b1;
    step(1);
    check_out("hold_redir", 1'b1, 8'h0A, 8'h0B);
    stall       = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 8'h40;
    #1;
    check("redir.req", {7'd0, imem_req}, 8'h00);
    step(1);
    redirect = 1'b0;
    #1;
    check("flush.valid", {7'd0, if_valid}, 8'h00);
    check("flush.req", {7'd0, imem_req}, 8'h00);
    step(1);
    check("r2.valid", {7'd0, if_valid}, 8'h00);
    check("r2.req", {7'd0, imem_req}, 8'h01);
    check("r2.addr", imem_addr, 8'h40);
    step(1);
    check("r3.valid", {7'd0, if_valid}, 8'h00);
    step(1);
    check_out("r4", 1'b1, 8'h40, 8'h41);
    step(1);
    check_out("r5", 1'b1, 8'h41, 8'h42);

    // PC wrap through FF.
    redirect    = 1'b1;
    redirect_pc = 8'hFE;
    step(1);
    redirect = 1'b0;
    step(1);
    check("wrap.addr0", imem_addr, 8'hFE);
    step(1);
    check("wrap.addr1", imem_addr, 8'hFF);
    step(1);
    check_out("wrap0", 1'b1, 8'hFE, 8'hFF);
    check("wrap.addr2", imem_addr, 8'h00);
    step(1);
    check_out("wrap1", 1'b1, 8'hFF, 8'h00);
    step(1);
    check_out("wrap2", 1'b1, 8'h00, 8'h01);

    // Back-to-back redirects: only 20 survives.
    redirect    = 1'b1;
    redirect_pc = 8'h10;
    step(1);
    redirect_pc = 8'h20;
    #1;
    check("b2b.valid0", {7'd0, if_valid}, 8'h00);
    step(1);
    redirect = 1'b0;
    #1;
    check("b2b.valid1", {7'd0, if_valid}, 8'h00);
    check("b2b.req1", {7'd0, imem_req}, 8'h00);
    step(1);
    check("b2b.valid2", {7'd0, if_valid}, 8'h00);
    check("b2b.addr", imem_addr, 8'h20);
    step(1);
    check("b2b.valid3", {7'd0, if_valid}, 8'h00);
    step(1);
    check_out("b2b0", 1'b1, 8'h20, 8'h21);
    step(1);
    check_out("b2b1", 1'b1, 8'h21, 8'h22);

    // One-cycle reset mid-stream with a stale response arriving after it.
    resetn       = 1'b0;
    force_rvalid = 1'b1;
    step(1);
    resetn       = 1'b0;
    force_rvalid = 1'b0;
    resetn       = 1'b1;
    #1;
    check_out("mreset", 1'b0, 8'h00, 8'h00);
    check("mreset.req", {7'd0, imem_req}, 8'h00);
    step(1);
    check("stale.valid", {7'd0, if_valid}, 8'h00);
    check("restart.addr", imem_addr, 8'h00);
    check("restart.req", {7'd0, imem_req}, 8'h01);
    step(1);
    check("restart.valid", {7'd0, if_valid}, 8'h00);
    step(1);
    check_out("restart0", 1'b1, 8'h00, 8'h01);
    step(1);
    check_out("restart1", 1'b1, 8'h01, 8'h02);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
